// File: rtl/dp_ram_port_arbiter.sv
// Round-robin arbiter and sequencer for port A of the dual-port block RAM.
// Shares the single RAM port between NUM_REQ requesters with valid/ready
// handshakes. Supports locked bursts capped at MAX_BURST beats. Read data
// returns tagged with the requester ID, aligned to the RAM's 2-stage read latency.
module dp_ram_port_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int NUM_COL    = 4,
    parameter int COL_WIDTH  = 8,
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = NUM_COL * COL_WIDTH,
    parameter int ID_WIDTH   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    parameter int MAX_BURST  = 16
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ-1:0]              req_lock,
    input  logic [NUM_REQ*NUM_COL-1:0]      req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
    output logic                            ram_en,
    output logic                            ram_reset,
    output logic [NUM_COL-1:0]              ram_wr_en,
    output logic [ADDR_WIDTH-1:0]           ram_addr,
    output logic [DATA_WIDTH-1:0]           ram_din,
    input  logic [DATA_WIDTH-1:0]           ram_dout,
    output logic                            rsp_valid,
    output logic [ID_WIDTH-1:0]             rsp_id,
    output logic [DATA_WIDTH-1:0]           rsp_rdata
);

    localparam int CNT_WIDTH = $clog2(MAX_BURST + 1);

    // state  | meaning
    // IDLE   | round-robin search from ptr over all requesters
    // LOCKED | only the owner may be granted; burst_cnt beats taken so far
    typedef enum logic {IDLE, LOCKED} state_t;

    state_t                 state, state_nxt;
    logic [ID_WIDTH-1:0]    ptr, ptr_nxt;
    logic [ID_WIDTH-1:0]    owner, owner_nxt;
    logic [CNT_WIDTH-1:0]   burst_cnt, burst_cnt_nxt;
    logic [ID_WIDTH-1:0]    grant_idx;
    logic                   found;
    int                     idx;
    logic [ID_WIDTH-1:0]    idx_w;
    logic                   accept;
    logic                   sel_lock;
    logic [NUM_COL-1:0]     sel_we;
    logic                   is_read;
    logic [2:0]             rd_vld;
    logic [2:0][ID_WIDTH-1:0] rd_id;

    function automatic logic [ID_WIDTH-1:0] wrap_inc(input logic [ID_WIDTH-1:0] i);
        return (int'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
    endfunction

    // The RAM pipeline must always advance so ram_reset can flush dout_a.
    assign ram_en    = 1'b1;
    assign rsp_rdata = ram_dout;
    assign rsp_valid = rd_vld[2];
    assign rsp_id    = rd_id[2];

    assign accept   = |(req_valid & req_ready);
    assign sel_lock = req_lock[grant_idx];
    assign sel_we   = req_we[grant_idx*NUM_COL +: NUM_COL];
    assign is_read  = accept && (sel_we == '0);

    // Grant selection; ram_reset doubles as the registered in-reset flag so
    // the first grant comes only after reset_n has been sampled high.
    always_comb begin
        req_ready = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        idx_w     = '0;
        if (!ram_reset) begin
            if (state == LOCKED) begin
                grant_idx        = owner;
                req_ready[owner] = req_valid[owner];
            end else begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    idx = int'(ptr) + k;
                    if (idx >= NUM_REQ) idx = idx - NUM_REQ;
                    idx_w = ID_WIDTH'(idx);
                    if (!found && req_valid[idx_w]) begin
                        found            = 1'b1;
                        grant_idx        = idx_w;
                        req_ready[idx_w] = 1'b1;
                    end
                end
            end
        end
    end

    // Next-state, pointer and burst bookkeeping on accepted beats.
    always_comb begin
        state_nxt     = state;
        ptr_nxt       = ptr;
        owner_nxt     = owner;
        burst_cnt_nxt = burst_cnt;
        if (accept) begin
            case (state)
                IDLE: begin
                    ptr_nxt = wrap_inc(grant_idx);
                    if (sel_lock && (MAX_BURST > 1)) begin
                        state_nxt     = LOCKED;
                        owner_nxt     = grant_idx;
                        burst_cnt_nxt = CNT_WIDTH'(1);
                    end
                end
                LOCKED: begin
                    burst_cnt_nxt = burst_cnt + 1'b1;
                    if (!sel_lock || (burst_cnt_nxt == CNT_WIDTH'(MAX_BURST))) begin
                        state_nxt = IDLE;
                        ptr_nxt   = wrap_inc(owner);
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            ptr       <= '0;
            owner     <= '0;
            burst_cnt <= '0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            owner     <= owner_nxt;
            burst_cnt <= burst_cnt_nxt;
        end
    end

    // RAM command registers; address and data hold when idle.
    always_ff @(posedge clk) begin
        ram_reset <= !reset_n;
        if (!reset_n) begin
            ram_wr_en <= '0;
            ram_addr  <= '0;
            ram_din   <= '0;
        end else if (accept) begin
            ram_wr_en <= sel_we;
            ram_addr  <= req_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
            ram_din   <= req_wdata[grant_idx*DATA_WIDTH +: DATA_WIDTH];
        end else begin
            ram_wr_en <= '0;
        end
    end

    // Read tag pipeline matching the command register plus the RAM's two stages.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_vld <= '0;
            rd_id  <= '0;
        end else begin
            rd_vld <= {rd_vld[1:0], is_read};
            rd_id  <= {rd_id[1:0], grant_idx};
        end
    end

endmodule

// File: tb/tb_dp_ram_port_arbiter.sv
// Directed bench for dp_ram_port_arbiter with a behavioural 2-stage RAM model.
module tb_dp_ram_port_arbiter;

    localparam int NR = 4;
    localparam int NC = 4;
    localparam int CW = 8;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int IW = 2;
    localparam int MB = 4;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [NR-1:0]     req_valid, req_ready, req_lock;
    logic [NR*NC-1:0]  req_we;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_wdata;
    logic              ram_en, ram_reset;
    logic [NC-1:0]     ram_wr_en;
    logic [AW-1:0]     ram_addr;
    logic [DW-1:0]     ram_din, ram_dout;
    logic              rsp_valid;
    logic [IW-1:0]     rsp_id;
    logic [DW-1:0]     rsp_rdata;

    logic [DW-1:0]     mem [1<<AW];
    logic [DW-1:0]     pipe;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dp_ram_port_arbiter #(
        .NUM_REQ(NR), .NUM_COL(NC), .COL_WIDTH(CW), .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW), .ID_WIDTH(IW), .MAX_BURST(MB)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_lock(req_lock),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .ram_en(ram_en), .ram_reset(ram_reset), .ram_wr_en(ram_wr_en),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_rdata(rsp_rdata)
    );

    // RAM port A model: read-first, pipe_a then dout_a, reset clears dout_a.
    always @(posedge clk) begin
        if (ram_en) begin
            for (int c = 0; c < NC; c++)
                if (ram_wr_en[c]) mem[ram_addr][c*CW +: CW] <= ram_din[c*CW +: CW];
            pipe     <= mem[ram_addr];
            ram_dout <= ram_reset ? '0 : pipe;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_reqs();
        req_valid = '0; req_lock = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    endtask

    task automatic set_req(input int i, input logic v, input logic lk,
                           input logic [NC-1:0] we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
        req_valid[i] = v;
        req_lock[i]  = lk;
        req_we[i*NC +: NC]    = we;
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic test_reset();
        clear_reqs();
        reset_n   = 1'b0;
        req_valid = 4'b1111;
        repeat (3) tick();
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rst_ready: got %b expected 0000", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %b expected 0", rsp_valid); end
        checks++; if (ram_en !== 1'b1) begin errors++; $display("FAIL rst_ram_en: got %b expected 1", ram_en); end
        checks++; if (ram_reset !== 1'b1) begin errors++; $display("FAIL rst_ram_reset: got %b expected 1", ram_reset); end
        checks++; if (ram_wr_en !== 4'b0000 || ram_addr !== '0 || ram_din !== '0) begin
            errors++; $display("FAIL rst_cmd: got we=%b addr=%h din=%h expected all zero", ram_wr_en, ram_addr, ram_din); end
        reset_n = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rst_release_early: got %b expected 0000", req_ready); end
        tick();
        #1;
        checks++; if (ram_reset !== 1'b0) begin errors++; $display("FAIL rst_ram_reset_low: got %b expected 0", ram_reset); end
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rst_first_grant: got %b expected 0001", req_ready); end
        clear_reqs();
        tick();
    endtask

    task automatic test_round_robin();
        logic [3:0] exp;
        clear_reqs();
        for (int i = 0; i < NR; i++) set_req(i, 1'b1, 1'b0, 4'b0000, AW'(16 + i), '0);
        for (int k = 0; k < 8; k++) begin
            #1;
            if (k < 5) begin
                exp = 4'(1 << (k % 4));
                checks++; if (req_ready !== exp) begin errors++; $display("FAIL rr_grant[%0d]: got %b expected %b", k, req_ready, exp); end
            end
            if (k == 4) req_valid = '0;
            if (k >= 3 && k <= 6) begin
                checks++; if (rsp_valid !== 1'b1 || rsp_id !== IW'(k - 3) || rsp_rdata !== 32'hC0DE0010 + DW'(k - 3)) begin
                    errors++; $display("FAIL rr_rsp[%0d]: got v=%b id=%0d data=%h expected v=1 id=%0d data=%h",
                                       k, rsp_valid, rsp_id, rsp_rdata, k - 3, 32'hC0DE0010 + DW'(k - 3)); end
            end else begin
                checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rr_rsp_idle[%0d]: got %b expected 0", k, rsp_valid); end
            end
            tick();
        end
    endtask

    task automatic test_write_read();
        clear_reqs();
        set_req(2, 1'b1, 1'b0, 4'b0101, 10'h005, 32'hAABBCCDD);
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL wr_grant: got %b expected 0100", req_ready); end
        tick();
        checks++; if (ram_wr_en !== 4'b0101 || ram_addr !== 10'h005 || ram_din !== 32'hAABBCCDD) begin
            errors++; $display("FAIL wr_cmd: got we=%b addr=%h din=%h expected we=0101 addr=005 din=aabbccdd", ram_wr_en, ram_addr, ram_din); end
        set_req(2, 1'b1, 1'b0, 4'b0000, 10'h005, '0);
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL rd_grant: got %b expected 0100", req_ready); end
        tick();
        clear_reqs();
        checks++; if (ram_wr_en !== 4'b0000 || ram_addr !== 10'h005) begin
            errors++; $display("FAIL rd_cmd: got we=%b addr=%h expected we=0000 addr=005", ram_wr_en, ram_addr); end
        tick();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL wr_no_rsp: got %b expected 0", rsp_valid); end
        tick();
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_rdata !== 32'h11BB33DD) begin
            errors++; $display("FAIL raw_rsp: got v=%b id=%0d data=%h expected v=1 id=2 data=11bb33dd", rsp_valid, rsp_id, rsp_rdata); end
        tick();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL raw_single: got %b expected 0", rsp_valid); end
    endtask

    task automatic test_locked_burst();
        clear_reqs();
        set_req(1, 1'b1, 1'b1, 4'b0000, 10'h020, '0);
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL lk_beat1: got %b expected 0010", req_ready); end
        tick();
        set_req(0, 1'b1, 1'b0, 4'b0000, 10'h030, '0);
        set_req(2, 1'b1, 1'b0, 4'b0000, 10'h032, '0);
        set_req(3, 1'b1, 1'b0, 4'b0000, 10'h033, '0);
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL lk_beat2: got %b expected 0010", req_ready); end
        tick();
        req_valid[1] = 1'b0;
        #1;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL lk_wait: got %b expected 0000", req_ready); end
        tick();
        req_valid[1] = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL lk_beat3: got %b expected 0010", req_ready); end
        tick();
        req_lock[1] = 1'b0;
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL lk_beat4: got %b expected 0010", req_ready); end
        tick();
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL lk_next: got %b expected 0100", req_ready); end
        clear_reqs();
        repeat (4) tick();
    endtask

    task automatic test_burst_cap();
        logic [3:0] exp_seq [12];
        exp_seq = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0100,
                    4'b1000, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010};
        clear_reqs();
        set_req(0, 1'b1, 1'b1, 4'b0000, 10'h040, '0);
        for (int k = 0; k < 12; k++) begin
            if (k == 1) begin
                set_req(1, 1'b1, 1'b0, 4'b0000, 10'h041, '0);
                set_req(2, 1'b1, 1'b0, 4'b0000, 10'h042, '0);
                set_req(3, 1'b1, 1'b0, 4'b0000, 10'h043, '0);
            end
            #1;
            checks++; if (req_ready !== exp_seq[k]) begin errors++; $display("FAIL cap_grant[%0d]: got %b expected %b", k, req_ready, exp_seq[k]); end
            if (k < 11) tick();
        end
        clear_reqs();
    endtask

    task automatic test_short_burst();
        clear_reqs();
        set_req(3, 1'b1, 1'b1, 4'b0000, 10'h060, '0);
        #1;
        checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL sb_beat1: got %b expected 1000", req_ready); end
        tick();
        set_req(0, 1'b1, 1'b0, 4'b0000, 10'h061, '0);
        set_req(1, 1'b1, 1'b0, 4'b0000, 10'h062, '0);
        set_req(2, 1'b1, 1'b0, 4'b0000, 10'h063, '0);
        req_lock[3] = 1'b0;
        #1;
        checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL sb_beat2: got %b expected 1000", req_ready); end
        tick();
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL sb_release: got %b expected 0001", req_ready); end
        clear_reqs();
        repeat (4) tick();
    endtask

    task automatic test_reset_during_reads();
        clear_reqs();
        set_req(1, 1'b1, 1'b1, 4'b0000, 10'h050, '0);
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL rr2_beat1: got %b expected 0010", req_ready); end
        tick();
        set_req(1, 1'b1, 1'b1, 4'b0000, 10'h051, '0);
        #1;
        tick();
        reset_n = 1'b0;
        clear_reqs();
        tick();
        checks++; if (rsp_valid !== 1'b0 || rsp_id !== '0) begin errors++; $display("FAIL mid_rst_rsp0: got v=%b id=%0d expected v=0 id=0", rsp_valid, rsp_id); end
        checks++; if (ram_reset !== 1'b1 || ram_addr !== '0 || ram_wr_en !== '0) begin
            errors++; $display("FAIL mid_rst_cmd: got rst=%b addr=%h we=%b expected rst=1 addr=0 we=0", ram_reset, ram_addr, ram_wr_en); end
        tick();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_rsp1: got %b expected 0", rsp_valid); end
        checks++; if (rsp_rdata !== '0) begin errors++; $display("FAIL mid_rst_dout: got %h expected 0", rsp_rdata); end
        tick();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_rsp2: got %b expected 0", rsp_valid); end
        reset_n = 1'b1;
        for (int i = 0; i < NR; i++) set_req(i, 1'b1, 1'b0, 4'b0000, AW'(16 + i), '0);
        #1;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL mid_rst_hold: got %b expected 0000", req_ready); end
        tick();
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL mid_rst_idle_ptr: got %b expected 0001", req_ready); end
        clear_reqs();
        tick();
    endtask

    initial begin
        for (int a = 0; a < (1 << AW); a++) mem[a] = 32'hC0DE0000 | DW'(a);
        mem[5] = 32'h11223344;
        reset_n = 1'b0;
        clear_reqs();
        test_reset();
        test_round_robin();
        test_write_read();
        test_locked_burst();
        test_burst_cap();
        test_short_burst();
        test_reset_during_reads();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dp_ram_port_arbiter.md
# dp_ram_port_arbiter

Round-robin arbiter and sequencer for port A (clk_a side) of the dual-port PS/PL block RAM. It shares that single port between NUM_REQ PL requesters using a valid/ready handshake and supports locked bursts with a bounded length. It drives the RAM command registers and keeps the RAM's 2-stage read pipeline enabled. Each read returns its data with the originating requester ID, aligned to the RAM's read latency.

## Interface

Parameters:
- NUM_REQ, 4: number of requesters; at least 2.
- NUM_COL, 4: byte-enable columns per word.
- COL_WIDTH, 8: bits per column.
- ADDR_WIDTH, 10: RAM word address width.
- DATA_WIDTH, NUM_COL*COL_WIDTH: word width (derived).
- ID_WIDTH, max(1, $clog2(NUM_REQ)): width of requester index.
- MAX_BURST, 16: maximum consecutive locked beats; at least 1.

Ports:
- clk, input, 1: single clock, also drives the RAM clk_a.
- reset_n, input, 1: synchronous, active-low reset.
- req_valid, input, NUM_REQ: per-requester command valid.
- req_ready, output, NUM_REQ: per-requester grant, one-hot or zero.
- req_lock, input, NUM_REQ: hold the grant after this beat.
- req_we, input, NUM_REQ*NUM_COL: column write mask; all zero means read.
- req_addr, input, NUM_REQ*ADDR_WIDTH: word address.
- req_wdata, input, NUM_REQ*DATA_WIDTH: write data.
- ram_en, output, 1: to RAM en_a.
- ram_reset, output, 1: to RAM reset_a.
- ram_wr_en, output, NUM_COL: to RAM wr_en_a.
- ram_addr, output, ADDR_WIDTH: to RAM addr_a.
- ram_din, output, DATA_WIDTH: to RAM din_a.
- ram_dout, input, DATA_WIDTH: from RAM dout_a.
- rsp_valid, output, 1: read data valid. There is no backpressure; the requester must accept it.
- rsp_id, output, ID_WIDTH: requester index of the returned read.
- rsp_rdata, output, DATA_WIDTH: equal to ram_dout.

## Operation

**Reset values.**
- ram_en = 1, held at 1 at all times so the RAM pipeline always advances and ram_reset can clear the RAM dout_a.
- ram_reset = 1 while reset_n is low, 0 otherwise (registered).
- ram_wr_en = 0, ram_addr = 0, ram_din = 0.
- rsp_valid = 0, rsp_id = 0.
- req_ready = 0.
- State = IDLE, round-robin pointer = 0, burst count = 0.
- Reads in flight are discarded; no rsp_valid is produced for them.

**Acceptance.** A beat is accepted on an edge where req_valid[i] and req_ready[i] are both high. At most one beat is accepted per cycle.

**Arbitration in IDLE.** req_ready is combinational. It grants the first asserted req_valid found searching upward, with wrap-around, from the pointer index. After an accepted beat from requester i, the pointer becomes (i+1) mod NUM_REQ.

**State machine:**
- IDLE → LOCKED when the accepted beat has req_lock[i]=1 and MAX_BURST > 1. The owner is set to i and the burst count to 1.
- LOCKED: req_ready = req_valid[owner] only; all others see 0. Each accepted beat increments the burst count.
- LOCKED → IDLE when an accepted beat has req_lock[owner]=0, or when the accepted beat brings the burst count to MAX_BURST (req_lock is ignored on that beat). The pointer becomes owner+1.
- LOCKED with the owner's valid low: the arbiter waits and stays LOCKED. No other requester is granted.

**Command path.**
- On each accepted beat, ram_wr_en, ram_addr and ram_din register the granted requester's fields.
- On a cycle with no accepted beat, ram_wr_en = 0; ram_addr and ram_din hold their values.
- A beat with a nonzero mask performs a partial write of the selected columns. It produces no response.
- A beat with an all-zero mask is a read. It pushes {1, i} into a 3-stage valid/ID shift register.

**Response.** rsp_valid and rsp_id are the last stage of the shift register. rsp_rdata passes ram_dout through.

**Port B collisions.** Same-address access on RAM port B (the PS side) in the same cycle is undefined and outside this block's scope.

## Timing

- **Grant.** req_ready is combinational from req_valid, state and pointer. It has zero-cycle latency.
- **Command to RAM.** A beat accepted at edge E appears on the ram_* outputs after E. The RAM samples it at E+1 (into pipe_a) and presents it on dout_a after E+2.
- **Read return.** rsp_valid, rsp_id and rsp_rdata are valid for exactly the one cycle after edge E+2.
- **Throughput.** Back-to-back reads give one response per cycle, in acceptance order.
- **Read after write.** A read accepted on the edge after a write to the same address returns the new data.
- **Reset mid-operation.** reset_n is sampled low at edge R.
  - After R: all outputs hold their reset values, and ram_reset = 1 clears the RAM dout_a at the next edge.
  - rsp_valid is 0 from R onward until new reads complete.
  - The first grant is possible in the cycle after reset_n is sampled high.

## Test plan

1. **Reset.** Hold reset_n = 0 for 3 cycles with all req_valid = 1 → req_ready = 0, rsp_valid = 0, ram_en = 1, ram_reset = 1. After release, req_ready = 0001.
2. **Round-robin.** Hold req_valid = 1111 with lock = 0 and reads to addresses 0x10–0x13 → grants 0, 1, 2, 3, 0 on consecutive cycles. rsp_id sequence 0, 1, 2, 3 starts 2 edges after the first acceptance, with rsp_rdata = mem[0x10..0x13].
3. **Write then read.** Requester 2 writes mask 0101, data 0xAABBCCDD to 0x05 (initial 0x11223344), then reads 0x05 → rsp_rdata = 0x11BB33DD, rsp_id = 2.
4. **Locked burst.** Requester 1 sends 4 beats with lock = 1,1,1,0 while the others are valid → only requester 1 is granted for 4 cycles. The next grant goes to requester 2.
5. **Burst cap.** With MAX_BURST = 4, requester 0 holds lock = 1 for 10 beats → release after the 4th beat. Requesters 1–3 are each granted once before requester 0 is granted again.
6. **Reset during reads.** Accept 2 reads, then drop reset_n at the next edge → no rsp_valid pulse appears, and state returns to IDLE with the pointer at 0.
